isa_dispatch: RTL and testbench
===============================

# isa_dispatch

Instruction sequencer for the cpoo core. It fetches each instruction word from program memory and decodes it into opcode and register operands. It then hands the operands to exactly one execution unit (isa_mov, and later the ALU and load/store units) over the `enabled`/`finished` handshake. Once the unit finishes, it retires the instruction and advances the PC.

## Interface
Parameters:
- `NUM_UNITS`, 8: number of execution units; opcode k (k < NUM_UNITS) selects unit k.
- `PC_W`, 16: program counter / memory address width.
- `TIMEOUT`, 1024: maximum cycles a unit may hold EXEC before a fault.

Ports:
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `run`  in  1  level; 1 = sequencer may fetch, 0 = stop at next instruction boundary.
- `mem_addr`  out  PC_W  program memory address.
- `mem_re`  out  1  memory read strobe, one-cycle pulse.
- `mem_rdata`  in  16  instruction word, valid the cycle after `mem_re`.
- `r0`  out  4  source register field, `ir[11:8]`, held through EXEC.
- `r1`  out  4  destination register field, `ir[7:4]`, held through EXEC.
- `unit_en`  out  NUM_UNITS  one-hot unit enable; all-zero outside EXEC.
- `unit_finished`  in  NUM_UNITS  per-unit completion flags.
- `pc`  out  PC_W  address of current/next instruction.
- `retired`  out  32  count of completed instructions; wraps.
- `halted`  out  1  sequencer stopped permanently until reset.
- `fault`  out  2  0 = none, 1 = illegal opcode, 2 = unit timeout, 3 = reserved.

## Operation
- Instruction format: `[15:12]` opcode, `[11:8]` r0, `[7:4]` r1, `[3:0]` ignored.
- Opcode 4'hE = NOP: no unit is enabled; it retires directly. Opcode 4'hF = HALT. Any other opcode ≥ NUM_UNITS is illegal.
- States and transitions:
  - IDLE: go to FETCH when `run`=1.
  - FETCH: `mem_addr`=pc, `mem_re`=1; go to LOAD.
  - LOAD: latch `mem_rdata` into ir; drive r0/r1.
    - opcode < NUM_UNITS: go to EXEC.
    - NOP: go to RELEASE.
    - HALT: go to STOP with fault 0.
    - illegal: go to STOP with fault 1.
  - EXEC: `unit_en[op]`=1, watchdog counting.
    - `unit_finished[op]`=1 sampled: go to RELEASE.
    - watchdog reaches TIMEOUT: go to STOP with fault 2.
  - RELEASE: `unit_en`=0 for exactly one cycle, so the unit sees the falling enable and clears `finished`; pc ← pc+1 (wraps modulo 2^PC_W); retired ← retired+1. Go to FETCH if `run`=1, else IDLE.
  - STOP: `halted`=1, `unit_en`=0; pc is not advanced. Only `rst_n` leaves STOP.
- `unit_finished` bits of non-selected units are ignored. A stale `finished` from the selected unit in the first EXEC cycle is honoured; units must clear it on enable fall, which RELEASE guarantees.
- Dropping `run` mid-instruction does not abort: the current instruction completes, then the sequencer idles. `retired` and pc are preserved.

## Timing
- Reset values, applied asynchronously while `rst_n`=0: state IDLE, pc 0, ir 0, r0/r1 0, `mem_addr` 0, `mem_re` 0, `unit_en` 0, `retired` 0, `halted` 0, `fault` 0, watchdog 0.
- Reset asserted mid-EXEC drops `unit_en` immediately (asynchronously).
- Cycle budget per instruction:
  - unit instruction: 1 FETCH + 1 LOAD + N EXEC + 1 RELEASE, where N ≥ 1 is the number of cycles until `finished` is sampled high.
  - NOP: 3 cycles.
  - HALT/illegal: STOP reached 2 cycles after FETCH.
- Watchdog clears on EXEC entry and increments each EXEC cycle with `finished` low. Fault 2 fires on the cycle the count equals TIMEOUT. `finished` sampled high on that same cycle wins, and the instruction retires.
- `unit_en` is never high in two consecutive instructions without an intervening zero cycle.

## Test plan
- Reset, `run`=1, memory[0]=16'h0120 (unit 0, r0=1, r1=2), unit 0 model finishes after 3 cycles → `unit_en`=8'h01 for 3 cycles; r0=1, r1=2 while enabled; then one zero cycle; pc=1, retired=1.
- Program NOP, NOP, HALT (16'hE000, 16'hE000, 16'hF000) → pc=2, retired=2, halted=1, fault=0, `unit_en` never nonzero.
- memory[0]=16'h9000 with NUM_UNITS=8 → halted=1, fault=1, pc=0, retired=0.
- Unit never finishes, TIMEOUT=16 → `unit_en` high exactly 16 cycles, then halted=1, fault=2, `unit_en`=0.
- pc preloaded via a program of 2^PC_W NOPs, PC_W=4 → pc wraps 15→0 and retired=16.
- `run` dropped during EXEC, then `rst_n` pulsed low mid-EXEC of a later instruction → first: instruction completes, state IDLE, retired incremented once; second: all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/isa_dispatch.sv
// Instruction sequencer for the cpoo core: fetch, decode, dispatch to one
// execution unit over an enable/finished handshake, then retire and advance pc.
module isa_dispatch #(
  parameter int unsigned NUM_UNITS = 8,
  parameter int unsigned PC_W      = 16,
  parameter int unsigned TIMEOUT   = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 run,
  output logic [PC_W-1:0]      mem_addr,
  output logic                 mem_re,
  input  logic [15:0]          mem_rdata,
  output logic [3:0]           r0,
  output logic [3:0]           r1,
  output logic [NUM_UNITS-1:0] unit_en,
  input  logic [NUM_UNITS-1:0] unit_finished,
  output logic [PC_W-1:0]      pc,
  output logic [31:0]          retired,
  output logic                 halted,
  output logic [1:0]           fault
);

  localparam int unsigned WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  localparam logic [3:0] OP_NOP  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_EXEC,
    S_RELEASE,
    S_STOP
  } state_t;

  state_t                state_q, state_d;
  logic [PC_W-1:0]       pc_q, pc_d;
  logic [15:4]           ir_q, ir_d;
  logic [31:0]           retired_q, retired_d;
  logic [1:0]            fault_q, fault_d;
  logic [WD_W-1:0]       wd_q, wd_d;

  logic [3:0]            op_ld;
  logic [3:0]            op_ir;
  logic [NUM_UNITS-1:0]  sel_oh;
  logic                  sel_fin;
  logic                  unused_bits;

  assign op_ld       = mem_rdata[15:12];
  assign op_ir       = ir_q[15:12];
  assign unused_bits = ^mem_rdata[3:0];

  // Only the unit addressed by the latched opcode is enabled or listened to.
  always_comb begin
    sel_oh  = '0;
    sel_fin = 1'b0;
    for (int unsigned i = 0; i < NUM_UNITS; i++) begin
      if (i == 32'(op_ir)) begin
        sel_oh[i] = 1'b1;
        sel_fin   = unit_finished[i];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    retired_d = retired_q;
    fault_d   = fault_q;
    wd_d      = wd_q;
    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        state_d = S_LOAD;
      end
      S_LOAD: begin
        ir_d = mem_rdata[15:4];
        wd_d = '0;
        if (32'(op_ld) < NUM_UNITS) begin
          state_d = S_EXEC;
        end else if (op_ld == OP_NOP) begin
          state_d = S_RELEASE;
        end else if (op_ld == OP_HALT) begin
          state_d = S_STOP;
          fault_d = 2'd0;
        end else begin
          state_d = S_STOP;
          fault_d = 2'd1;
        end
      end
      S_EXEC: begin
        // finished on the watchdog's last cycle still retires the instruction
        if (sel_fin) begin
          state_d = S_RELEASE;
        end else if (wd_q == WD_LAST) begin
          state_d = S_STOP;
          fault_d = 2'd2;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      S_RELEASE: begin
        pc_d      = pc_q + PC_W'(1);
        retired_d = retired_q + 32'd1;
        state_d   = run ? S_FETCH : S_IDLE;
      end
      S_STOP: begin
        state_d = S_STOP;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      ir_q      <= '0;
      retired_q <= '0;
      fault_q   <= '0;
      wd_q      <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      retired_q <= retired_d;
      fault_q   <= fault_d;
      wd_q      <= wd_d;
    end
  end

  // Outputs decode straight from state so reset clears unit_en without a clock.
  assign mem_addr = pc_q;
  assign mem_re   = (state_q == S_FETCH);
  assign unit_en  = (state_q == S_EXEC) ? sel_oh : '0;
  assign r0       = ir_q[11:8];
  assign r1       = ir_q[7:4];
  assign pc       = pc_q;
  assign retired  = retired_q;
  assign halted   = (state_q == S_STOP);
  assign fault    = fault_q;

endmodule

// File: tb/tb_isa_dispatch.sv
// Directed bench for isa_dispatch: small program memory, a unit-0 model with
// programmable latency, and hand-computed expectations per scenario.
module tb_isa_dispatch;

  localparam int unsigned NU  = 8;
  localparam int unsigned PCW = 4;
  localparam int unsigned TO  = 16;

  logic           clk;
  logic           rst_n;
  logic           run;
  logic [PCW-1:0] mem_addr;
  logic           mem_re;
  logic [15:0]    mem_rdata;
  logic [3:0]     r0, r1;
  logic [NU-1:0]  unit_en;
  logic [NU-1:0]  unit_finished;
  logic [PCW-1:0] pc;
  logic [31:0]    retired;
  logic           halted;
  logic [1:0]     fault;

  isa_dispatch #(.NUM_UNITS(NU), .PC_W(PCW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_rdata(mem_rdata),
    .r0(r0), .r1(r1), .unit_en(unit_en), .unit_finished(unit_finished),
    .pc(pc), .retired(retired), .halted(halted), .fault(fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] mem [16];
  always @(posedge clk) if (mem_re) mem_rdata <= mem[mem_addr];

  // Unit 0 raises finished on its lat-th enabled cycle; other units hold
  // finished high permanently and must be ignored.
  int  lat;
  bit  never;
  int  ucnt;
  always @(posedge clk) ucnt <= unit_en[0] ? ucnt + 1 : 0;
  assign unit_finished = {{(NU-1){1'b1}}, (unit_en[0] && !never && (ucnt == lat - 1))};

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int en_cycles, en_rises, r_bad, cyc_halt;
  bit prev_en;
  logic [3:0] exp_r0, exp_r1;

  task automatic load_prog(input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2);
    for (int i = 0; i < 16; i++) mem[i] = 16'hF000;
    mem[0] = w0; mem[1] = w1; mem[2] = w2;
  endtask

  task automatic restart();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic watch(input string tag, input int budget);
    bit hit;
    en_cycles = 0; en_rises = 0; r_bad = 0; cyc_halt = 0; prev_en = 0; hit = 0;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      if (unit_en != '0) begin
        en_cycles++;
        if (!prev_en) en_rises++;
        if (r0 != exp_r0 || r1 != exp_r1) r_bad++;
      end
      prev_en = (unit_en != '0);
      if (halted) begin
        cyc_halt = c;
        hit = 1;
        break;
      end
    end
    check({tag, "_halt_reached"}, 32'(hit), 32'd1);
  endtask

  task automatic wait_en(input string tag, input int budget);
    bit hit;
    hit = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (unit_en != '0) begin hit = 1; break; end
    end
    check({tag, "_en_seen"}, 32'(hit), 32'd1);
  endtask

  initial begin
    int pcmax, nre;
    bit hit;
    rst_n = 1'b0; run = 1'b0; lat = 3; never = 0;
    exp_r0 = 4'd1; exp_r1 = 4'd2;
    load_prog(16'hF000, 16'hF000, 16'hF000);
    #12;
    check("rst_pc", 32'(pc), 0);
    check("rst_retired", retired, 0);
    check("rst_unit_en", 32'(unit_en), 0);
    check("rst_mem_re", 32'(mem_re), 0);
    check("rst_halted_fault", {29'd0, halted, fault}, 0);

    // single unit-0 instruction, 3-cycle latency, then HALT
    load_prog(16'h0120, 16'hF000, 16'hF000);
    run = 1'b1; restart();
    watch("t1", 60);
    check("t1_en_cycles", en_cycles, 3);
    check("t1_r_fields", r_bad, 0);
    check("t1_cycles", cyc_halt, 9);
    check("t1_pc", 32'(pc), 1);
    check("t1_retired", retired, 1);
    check("t1_fault", 32'(fault), 0);
    check("t1_en_stop", 32'(unit_en), 0);

    // back-to-back unit instructions must be separated by a zero-enable cycle
    load_prog(16'h0120, 16'h0120, 16'hF000);
    restart();
    watch("t1b", 60);
    check("t1b_en_cycles", en_cycles, 6);
    check("t1b_en_rises", en_rises, 2);
    check("t1b_retired", retired, 2);

    // NOP NOP HALT
    load_prog(16'hE000, 16'hE000, 16'hF000);
    restart();
    watch("t2", 60);
    check("t2_cycles", cyc_halt, 9);
    check("t2_en_cycles", en_cycles, 0);
    check("t2_pc", 32'(pc), 2);
    check("t2_retired", retired, 2);
    check("t2_fault", 32'(fault), 0);

    // illegal opcode 9 with 8 units
    load_prog(16'h9000, 16'hE000, 16'hE000);
    restart();
    watch("t3", 20);
    check("t3_cycles", cyc_halt, 3);
    check("t3_fault", 32'(fault), 1);
    check("t3_pc", 32'(pc), 0);
    check("t3_retired", retired, 0);

    // unit never finishes: watchdog fault after exactly TIMEOUT enabled cycles
    never = 1;
    load_prog(16'h0120, 16'hF000, 16'hF000);
    restart();
    watch("t4", 80);
    check("t4_en_cycles", en_cycles, 16);
    check("t4_cycles", cyc_halt, 19);
    check("t4_fault", 32'(fault), 2);
    check("t4_en_stop", 32'(unit_en), 0);
    check("t4_retired", retired, 0);

    // finished on the TIMEOUT-th cycle wins over the watchdog
    never = 0; lat = 16;
    restart();
    watch("t4b", 80);
    check("t4b_en_cycles", en_cycles, 16);
    check("t4b_fault", 32'(fault), 0);
    check("t4b_retired", retired, 1);

    // 16 NOPs with a 4-bit pc: pc wraps 15 -> 0
    for (int i = 0; i < 16; i++) mem[i] = 16'hE000;
    restart();
    pcmax = 0; hit = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (int'(pc) > pcmax) pcmax = int'(pc);
      if (retired == 32'd16) begin hit = 1; break; end
    end
    check("t5_reached16", 32'(hit), 1);
    check("t5_pc_wrap", 32'(pc), 0);
    check("t5_pcmax", pcmax, 15);
    run = 1'b0;

    // run dropped mid-EXEC: finish, then idle
    lat = 5;
    load_prog(16'h0120, 16'h0120, 16'hF000);
    run = 1'b1; restart();
    wait_en("t6a", 20);
    run = 1'b0;
    nre = 0;
    repeat (15) begin
      @(negedge clk);
      if (mem_re) nre++;
    end
    check("t6_retired", retired, 1);
    check("t6_pc", 32'(pc), 1);
    check("t6_no_fetch", nre, 0);
    check("t6_idle", {30'd0, halted, (unit_en != '0)}, 0);

    // resume, then asynchronous reset mid-EXEC with the clock held low
    run = 1'b1;
    wait_en("t6b", 20);
    #1 rst_n = 1'b0;
    #1;
    check("t6_arst_en", 32'(unit_en), 0);
    check("t6_arst_pc_ret", {retired[27:0], pc}, 0);
    check("t6_arst_r", {24'd0, r0, r1}, 0);
    check("t6_arst_misc", {28'd0, mem_re, halted, fault}, 0);
    check("t6_arst_addr", 32'(mem_addr), 0);
    run = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
